// File: rtl/mips_mem_arbiter_pkg.sv
// Shared types for the MIPS memory arbiter: FSM state encoding, master IDs and small helpers.
package mips_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } arb_master_e;

  // Wide enough for READ_LATENCY-2 with the maximum legal latency of 4.
  localparam int LAT_CNT_W = 2;

  function automatic logic is_misaligned(input logic [1:0] byte_lsb);
    return byte_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mips_rr_arb2.sv
// Two-way round-robin picker: on a tie, the master that did not win last time is granted.
module mips_rr_arb2
  import mips_mem_arbiter_pkg::*;
(
  input  logic [1:0]  req_i,
  input  arb_master_e last_grant_i,
  output logic [1:0]  grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (req_i[0] && (!req_i[1] || last_grant_i == ARB_M1)) begin
      grant_o = 2'b01;
    end else if (req_i[1]) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port RAM arbiter between the MIPS core (M0) and loader/debug port (M1), one transaction at a time.
// Define MEM_ARB_FIXED_PRI_EN for fixed priority (M1 wins ties); default is round-robin.
module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [LAT_CNT_W-1:0] WAIT_INIT =
    LAT_CNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  arb_state_e           state_q, state_d;
  arb_master_e          owner_q, owner_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;

  logic [1:0]  req;
  arb_master_e win;

  assign req = {m1_req_i, m0_req_i};

`ifdef MEM_ARB_FIXED_PRI_EN
  assign win = m1_req_i ? ARB_M1 : ARB_M0;
`else
  logic [1:0]  grant;
  arb_master_e last_grant_q, last_grant_d;

  mips_rr_arb2 u_rr_arb2 (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign win = (grant == 2'b10) ? ARB_M1 : ARB_M0;
  // Captured transactions always issue, so updating at capture equals updating at gnt.
  assign last_grant_d = (state_q == ARB_IDLE && |req) ? win : last_grant_q;

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= ARB_M1;
    else     last_grant_q <= last_grant_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= ARB_M0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_cnt_d   = lat_cnt_q;
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    rdata_o     = '0;
    err_o       = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          owner_d = win;
          we_d    = (win == ARB_M1) ? m1_we_i    : m0_we_i;
          addr_d  = (win == ARB_M1) ? m1_addr_i  : m0_addr_i;
          wdata_d = (win == ARB_M1) ? m1_wdata_i : m0_wdata_i;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        m0_gnt_o = (owner_q == ARB_M0);
        m1_gnt_o = (owner_q == ARB_M1);
        if (is_misaligned(addr_q[1:0])) begin
          err_o   = 1'b1;
          state_d = ARB_IDLE;
        end else begin
          mem_en_o    = 1'b1;
          mem_we_o    = we_q;
          mem_addr_o  = addr_q;
          mem_wdata_o = wdata_q;
          if (we_q) begin
            state_d = ARB_IDLE;
          end else if (READ_LATENCY == 1) begin
            state_d = ARB_RESP;
          end else begin
            lat_cnt_d = WAIT_INIT;
            state_d   = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        if (lat_cnt_q == '0) state_d = ARB_RESP;
        else                 lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
      end
      ARB_RESP: begin
        m0_rvalid_o = (owner_q == ARB_M0);
        m1_rvalid_o = (owner_q == ARB_M1);
        rdata_o     = mem_rdata_i;
        state_d     = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: a READ_LATENCY=1 instance and a READ_LATENCY=3 instance.
module tb_mips_mem_arbiter;

  logic clk, rst;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, err, mem_en, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic        s_m0_req;
  logic [31:0] s_m0_addr;
  logic        s_m0_gnt, s_m0_rvalid, s_m1_gnt, s_m1_rvalid, s_err, s_mem_en, s_mem_we;
  logic [31:0] s_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;
  int we_cnt = 0;

  logic [31:0] ram  [0:63];
  logic [31:0] ram3 [0:63];

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .rdata_o(rdata), .err_o(err),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .m0_req_i(s_m0_req), .m0_we_i(1'b0), .m0_addr_i(s_m0_addr), .m0_wdata_i(32'h0),
    .m0_gnt_o(s_m0_gnt), .m0_rvalid_o(s_m0_rvalid),
    .m1_req_i(1'b0), .m1_we_i(1'b0), .m1_addr_i(32'h0), .m1_wdata_i(32'h0),
    .m1_gnt_o(s_m1_gnt), .m1_rvalid_o(s_m1_rvalid),
    .rdata_o(s_rdata), .err_o(s_err),
    .mem_en_o(s_mem_en), .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata),
    .mem_rdata_i(s_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: read data is registered on the enable edge and held afterwards.
  always @(posedge clk) begin
    if (rst) begin
      ram[4]    <= 32'hDEADBEEF;
      ram[5]    <= 32'hCAFEF00D;
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:2]];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      ram3[4]     <= 32'hDEADBEEF;
      s_mem_rdata <= 32'h0;
    end else if (s_mem_en) begin
      if (s_mem_we) ram3[s_mem_addr[7:2]] <= s_mem_wdata;
      else          s_mem_rdata <= ram3[s_mem_addr[7:2]];
    end
  end

  always @(posedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step(); step();
    total_cnt++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, err, mem_en, mem_we} !== 7'b0) $display("FAIL reset_ctrl: got %b want 0000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, err, mem_en, mem_we}); else pass_cnt++;
    total_cnt++; if ({mem_addr, mem_wdata, rdata} !== 96'h0) $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, rdata}); else pass_cnt++;
    total_cnt++; if ({s_m0_gnt, s_m0_rvalid, s_err, s_mem_en} !== 4'b0) $display("FAIL reset_lat3: got %b want 0000", {s_m0_gnt, s_m0_rvalid, s_err, s_mem_en}); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_read_lat1();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    step();
    total_cnt++; if ({m0_gnt, m1_gnt, err} !== 3'b100) $display("FAIL rd_gnt: got %b want 100", {m0_gnt, m1_gnt, err}); else pass_cnt++;
    total_cnt++; if ({mem_en, mem_we} !== 2'b10) $display("FAIL rd_mem_en: got %b want 10", {mem_en, mem_we}); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'h10) $display("FAIL rd_mem_addr: got %h want 00000010", mem_addr); else pass_cnt++;
    m0_req = 1'b0;
    step();
    total_cnt++; if ({m0_rvalid, m1_rvalid, m0_gnt} !== 3'b100) $display("FAIL rd_rvalid: got %b want 100", {m0_rvalid, m1_rvalid, m0_gnt}); else pass_cnt++;
    total_cnt++; if (rdata !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", rdata); else pass_cnt++;
    step();
    total_cnt++; if ({m0_rvalid, rdata} !== 33'h0) $display("FAIL rd_after: got %h want 0", {m0_rvalid, rdata}); else pass_cnt++;
  endtask

  task automatic test_rr_tie();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h14;
    step();
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL tie1_gnt: got %b want 01", {m1_gnt, m0_gnt}); else pass_cnt++;
    m0_req = 1'b0;
    step();
    total_cnt++; if ({m1_rvalid, m0_rvalid} !== 2'b01 || rdata !== 32'hDEADBEEF) $display("FAIL tie1_resp: got %b/%h want 01/deadbeef", {m1_rvalid, m0_rvalid}, rdata); else pass_cnt++;
    m0_req = 1'b1;
    step();
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b00) $display("FAIL tie_idle_gnt: got %b want 00", {m1_gnt, m0_gnt}); else pass_cnt++;
    step();
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b10) $display("FAIL tie2_gnt: got %b want 10", {m1_gnt, m0_gnt}); else pass_cnt++;
    m1_req = 1'b0;
    step();
    total_cnt++; if ({m1_rvalid, m0_rvalid} !== 2'b10 || rdata !== 32'hCAFEF00D) $display("FAIL tie2_resp: got %b/%h want 10/cafef00d", {m1_rvalid, m0_rvalid}, rdata); else pass_cnt++;
    step();
    step();
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL tie3_gnt: got %b want 01", {m1_gnt, m0_gnt}); else pass_cnt++;
    m0_req = 1'b0;
    step();
    total_cnt++; if ({m1_rvalid, m0_rvalid} !== 2'b01) $display("FAIL tie3_resp: got %b want 01", {m1_rvalid, m0_rvalid}); else pass_cnt++;
    step();
  endtask

  task automatic test_write_read();
    int w0;
    w0 = we_cnt;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    step();
    total_cnt++; if ({m1_gnt, m0_gnt, mem_en, mem_we} !== 4'b1011) $display("FAIL wr_issue: got %b want 1011", {m1_gnt, m0_gnt, mem_en, mem_we}); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) $display("FAIL wr_bus: got %h/%h want 00000020/12345678", mem_addr, mem_wdata); else pass_cnt++;
    m1_req = 1'b0; m1_we = 1'b0;
    step();
    total_cnt++; if ({m1_gnt, m1_rvalid, mem_en} !== 3'b000) $display("FAIL wr_done: got %b want 000", {m1_gnt, m1_rvalid, mem_en}); else pass_cnt++;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
    step();
    total_cnt++; if (m0_gnt !== 1'b1) $display("FAIL wr_rd_gnt: got %b want 1", m0_gnt); else pass_cnt++;
    m0_req = 1'b0;
    step();
    total_cnt++; if (m0_rvalid !== 1'b1 || rdata !== 32'h12345678) $display("FAIL wr_rd_data: got %b/%h want 1/12345678", m0_rvalid, rdata); else pass_cnt++;
    total_cnt++; if (we_cnt - w0 !== 1) $display("FAIL wr_pulses: got %0d want 1", we_cnt - w0); else pass_cnt++;
    step();
  endtask

  task automatic test_misaligned();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h6;
    step();
    total_cnt++; if ({m0_gnt, m1_gnt, err, mem_en} !== 4'b1010) $display("FAIL mis_issue: got %b want 1010", {m0_gnt, m1_gnt, err, mem_en}); else pass_cnt++;
    m0_req = 1'b0;
    step();
    total_cnt++; if ({m0_rvalid, err, mem_en} !== 3'b000) $display("FAIL mis_next: got %b want 000", {m0_rvalid, err, mem_en}); else pass_cnt++;
    step();
    total_cnt++; if ({m0_rvalid, m0_gnt} !== 2'b00) $display("FAIL mis_later: got %b want 00", {m0_rvalid, m0_gnt}); else pass_cnt++;
  endtask

  task automatic test_lat3_and_rst();
    logic seen;
    s_m0_req = 1'b1; s_m0_addr = 32'h10;
    step();
    total_cnt++; if ({s_m0_gnt, s_mem_en} !== 2'b11) $display("FAIL l3_gnt: got %b want 11", {s_m0_gnt, s_mem_en}); else pass_cnt++;
    s_m0_req = 1'b0;
    step();
    total_cnt++; if ({s_mem_en, s_m0_rvalid} !== 2'b00) $display("FAIL l3_wait1: got %b want 00", {s_mem_en, s_m0_rvalid}); else pass_cnt++;
    step();
    total_cnt++; if (s_m0_rvalid !== 1'b0) $display("FAIL l3_wait2: got %b want 0", s_m0_rvalid); else pass_cnt++;
    step();
    total_cnt++; if (s_m0_rvalid !== 1'b1 || s_rdata !== 32'hDEADBEEF) $display("FAIL l3_resp: got %b/%h want 1/deadbeef", s_m0_rvalid, s_rdata); else pass_cnt++;
    step();
    s_m0_req = 1'b1;
    step();
    total_cnt++; if (s_m0_gnt !== 1'b1) $display("FAIL l3r_gnt: got %b want 1", s_m0_gnt); else pass_cnt++;
    s_m0_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++; if ({s_m0_gnt, s_m1_gnt, s_m0_rvalid, s_m1_rvalid, s_err, s_mem_en, s_mem_we, s_rdata} !== 39'h0) $display("FAIL l3r_clear: got %h want 0", {s_m0_gnt, s_m1_gnt, s_m0_rvalid, s_m1_rvalid, s_err, s_mem_en, s_mem_we, s_rdata}); else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen = seen | s_m0_rvalid | s_m1_rvalid;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL l3r_no_rvalid: got %b want 0", seen); else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [4];
`ifdef MEM_ARB_FIXED_PRI_EN
    exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`endif
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h30; m0_wdata = 32'h1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h34; m1_wdata = 32'h2;
    for (int k = 0; k < 4; k++) begin
      step();
      total_cnt++; if ({m1_gnt, m0_gnt} !== exp_g[k]) $display("FAIL cont_gnt%0d: got %b want %b", k, {m1_gnt, m0_gnt}, exp_g[k]); else pass_cnt++;
      step();
      total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b00) $display("FAIL cont_idle%0d: got %b want 00", k, {m1_gnt, m0_gnt}); else pass_cnt++;
    end
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    step(); step();
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    s_m0_req = 1'b0; s_m0_addr = 32'h0;
    test_reset();
    test_read_lat1();
    test_rr_tie();
    test_write_read();
    test_misaligned();
    test_lat3_and_rst();
    test_contention();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
